// File: rtl/decode_stage.sv
// Decode stage: 2-entry {instr, pc} buffer with combinational decode of the head entry; one-edge latency when empty.
// Backpressure: in_ready = (count < 2) from registered state only; flush and reset discard all entries.
module sync_fifo #(
  parameter int W     = 96,
  parameter int DEPTH = 2,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem_q[head_q];

  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push && !full) begin
        mem_d[tail_q] = wdata;
        tail_d        = ptr_inc(tail_q);
      end
      if (pop && !empty) begin
        head_d = ptr_inc(head_q);
      end
      // Simultaneous push and pop nets to zero change in occupancy.
      case ({push && !full, pop && !empty})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end
endmodule

module decode_stage (
  input  logic        clock,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  input  logic [31:0] in_instr,
  input  logic [63:0] in_pc,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [5:0]  out_opcode,
  output logic [4:0]  out_rd,
  output logic [4:0]  out_rs,
  output logic [4:0]  out_rt,
  output logic [63:0] out_imm,
  output logic [63:0] out_pc,
  output logic [63:0] out_target,
  output logic [2:0]  out_class,
  output logic        out_illegal
);
  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] pc;
  } entry_t;

  entry_t     wr_dat;
  entry_t     head_dat;
  logic [1:0] count;
  logic       full;
  logic       empty;
  logic       push;
  logic       pop;
  logic [63:0] imm_sext;

  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;
  assign wr_dat    = '{instr: in_instr, pc: in_pc};

  sync_fifo #(.W($bits(entry_t)), .DEPTH(2)) u_fifo (
    .clock (clock),
    .reset (reset),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .wdata (wr_dat),
    .rdata (head_dat),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign imm_sext = {{48{head_dat.instr[15]}}, head_dat.instr[15:0]};

  always_comb begin
    out_opcode  = '0;
    out_rd      = '0;
    out_rs      = '0;
    out_rt      = '0;
    out_imm     = '0;
    out_pc      = '0;
    out_target  = '0;
    out_class   = 3'd0;
    out_illegal = 1'b0;
    // Stale storage contents never leak out while the buffer is empty.
    if (out_valid) begin
      out_opcode = head_dat.instr[31:26];
      out_rd     = head_dat.instr[25:21];
      out_rs     = head_dat.instr[20:16];
      out_rt     = head_dat.instr[15:11];
      out_imm    = imm_sext;
      out_pc     = head_dat.pc;
      out_target = head_dat.pc + {imm_sext[61:0], 2'b00};
      if (head_dat.instr[31:26] <= 6'h05) begin
        out_class = head_dat.instr[28:26];
      end else begin
        out_class   = 3'd7;
        out_illegal = 1'b1;
      end
    end
  end

  logic unused_count;
  assign unused_count = ^count;
endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: hand-computed expectations for decode fields, buffering, flush and reset.
module tb_decode_stage;
  logic        clock = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [31:0] in_instr;
  logic [63:0] in_pc;
  logic        in_ready, out_valid, out_illegal;
  logic [5:0]  out_opcode;
  logic [4:0]  out_rd, out_rs, out_rt;
  logic [63:0] out_imm, out_pc, out_target;
  logic [2:0]  out_class;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  decode_stage dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_rd(out_rd), .out_rs(out_rs), .out_rt(out_rt),
    .out_imm(out_imm), .out_pc(out_pc), .out_target(out_target),
    .out_class(out_class), .out_illegal(out_illegal)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [63:0] pc, input logic ordy);
    in_valid  = v;
    in_instr  = ins;
    in_pc     = pc;
    out_ready = ordy;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0;
    drive(1'b0, 32'h0, 64'h0, 1'b0);
    step(); step();
    reset = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_opcode", out_opcode, 0);
    chk("rst_pc", out_pc, 0);
    chk("rst_target", out_target, 0);
    chk("rst_class", out_class, 0);
    chk("rst_illegal", out_illegal, 0);

    // Single pass ADDI
    drive(1'b1, 32'h0443_0005, 64'h100, 1'b1);
    step();
    drive(1'b0, 32'h0, 64'h0, 1'b1);
    chk("addi_valid", out_valid, 1);
    chk("addi_opcode", out_opcode, 1);
    chk("addi_class", out_class, 1);
    chk("addi_rd", out_rd, 2);
    chk("addi_rs", out_rs, 3);
    chk("addi_rt", out_rt, 0);
    chk("addi_imm", out_imm, 5);
    chk("addi_pc", out_pc, 64'h100);
    chk("addi_target", out_target, 64'h114);
    step();
    chk("addi_popped", out_valid, 0);

    // Backpressure: third push refused, then drain in order
    drive(1'b1, 32'h0800_0010, 64'h200, 1'b0);
    step();
    chk("bp_ready1", in_ready, 1);
    drive(1'b1, 32'h0C00_0020, 64'h204, 1'b0);
    step();
    chk("bp_ready2", in_ready, 0);
    chk("bp_head_pc", out_pc, 64'h200);
    drive(1'b1, 32'h0000_0000, 64'h208, 1'b0);
    step();
    chk("bp_ready3", in_ready, 0);
    drive(1'b0, 32'h0, 64'h0, 1'b1);
    chk("bp_d0_pc", out_pc, 64'h200);
    chk("bp_d0_class", out_class, 2);
    chk("bp_d0_target", out_target, 64'h240);
    step();
    chk("bp_d1_pc", out_pc, 64'h204);
    chk("bp_d1_class", out_class, 3);
    chk("bp_d1_ready", in_ready, 1);
    step();
    chk("bp_no_third", out_valid, 0);

    // Sign extension with wrap-below
    drive(1'b1, 32'h1000_FFFF, 64'h8, 1'b0);
    step();
    chk("beq_class", out_class, 4);
    chk("beq_imm", out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("beq_target", out_target, 64'h4);

    // Simultaneous push and pop at count 1: head advances, count stays 1
    drive(1'b1, 32'h1400_0001, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1);
    step();
    drive(1'b0, 32'h0, 64'h0, 1'b0);
    chk("pp_valid", out_valid, 1);
    chk("pp_ready", in_ready, 1);
    chk("jal_class", out_class, 5);
    chk("jal_target_wrap", out_target, 64'h0);

    // Illegal opcode sits behind the JAL and is popped normally
    drive(1'b1, 32'hFC00_0000, 64'h300, 1'b1);
    step();
    drive(1'b0, 32'h0, 64'h0, 1'b0);
    chk("ill_class", out_class, 7);
    chk("ill_flag", out_illegal, 1);
    chk("ill_pc", out_pc, 64'h300);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("ill_popped", out_valid, 0);

    // Flush with concurrent push and pop at count 2
    drive(1'b1, 32'h0000_0000, 64'h400, 1'b0);
    step();
    drive(1'b1, 32'h0000_0000, 64'h404, 1'b0);
    step();
    chk("fl_full", in_ready, 0);
    drive(1'b1, 32'h0000_0000, 64'h408, 1'b1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, 32'h0, 64'h0, 1'b0);
    chk("fl_valid", out_valid, 0);
    chk("fl_ready", in_ready, 1);

    // Reset mid-stream with count 1 and a push pending
    drive(1'b1, 32'h0000_0000, 64'h500, 1'b0);
    step();
    drive(1'b1, 32'h0000_0000, 64'h504, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    drive(1'b0, 32'h0, 64'h0, 1'b0);
    chk("mr_valid", out_valid, 0);
    chk("mr_ready", in_ready, 1);
    drive(1'b1, 32'h0800_0003, 64'h600, 1'b0);
    step();
    drive(1'b0, 32'h0, 64'h0, 1'b0);
    chk("mr_head_pc", out_pc, 64'h600);
    chk("mr_head_imm", out_imm, 64'h3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
